// File: rtl/hilo_wr_sched.sv
// Arbitrates the register-file write port between single-word WB writes and
// 64-bit HI/LO results from the mul/div unit. It also tracks HI/LO hazards for ID.
module hilo_wr_sched #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int LO_ADDR    = 32,
    parameter int HI_ADDR    = 33,
    parameter int MAX_WAIT   = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      md_start_i,
    input  logic                      md_done_i,
    input  logic [2*DATA_WIDTH-1:0]   md_result_i,
    input  logic                      id_valid_i,
    input  logic [ADDR_WIDTH-1:0]     id_raddr1_i,
    input  logic [ADDR_WIDTH-1:0]     id_raddr2_i,
    input  logic                      id_hilo_wr_i,
    output logic                      id_stall_o,
    input  logic                      wb_wen_i,
    input  logic [ADDR_WIDTH-1:0]     wb_waddr_i,
    input  logic [DATA_WIDTH-1:0]     wb_wdata_i,
    output logic                      wb_stall_o,
    output logic                      rf_wen_o,
    output logic [ADDR_WIDTH-1:0]     rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      rf_double_en_o,
    output logic [2*DATA_WIDTH-1:0]   rf_double_wdata_o,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0]         MAXW = CW'(MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] LO_A = ADDR_WIDTH'(LO_ADDR);
    localparam logic [ADDR_WIDTH-1:0] HI_A = ADDR_WIDTH'(HI_ADDR);

    typedef enum logic [1:0] {IDLE, BUSY, PEND} state_t;

    state_t                    state_q;
    logic [2*DATA_WIDTH-1:0]   buf_q;
    logic [CW-1:0]             wait_cnt_q;
    logic                      err_q;

    logic pend, timeout, force_dbl, rd_hilo, wb_hilo;

    always_comb begin
        pend      = (state_q == PEND);
        timeout   = (wait_cnt_q == MAXW);
        // An idle WB slot drains the buffer at once. Otherwise WB wins until the wait budget is used up.
        force_dbl = pend & (~wb_wen_i | timeout);
        rd_hilo   = (id_raddr1_i == LO_A) | (id_raddr1_i == HI_A) |
                    (id_raddr2_i == LO_A) | (id_raddr2_i == HI_A) | id_hilo_wr_i;
        wb_hilo   = (wb_waddr_i == LO_A) | (wb_waddr_i == HI_A);
    end

    assign busy_o            = (state_q != IDLE);
    assign err_o             = err_q;
    assign rf_waddr_o        = wb_waddr_i;
    assign rf_wdata_o        = wb_wdata_i;
    assign rf_double_wdata_o = buf_q;
    assign rf_double_en_o    = rstn & force_dbl;
    assign wb_stall_o        = rstn & pend & wb_wen_i & timeout;
    assign rf_wen_o          = rstn & wb_wen_i & ~(pend & timeout);
    assign id_stall_o        = rstn & busy_o & id_valid_i & rd_hilo;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_start_i) state_q <= BUSY;
                    if (md_done_i)  err_q   <= 1'b1;
                end
                BUSY: begin
                    if (md_done_i) begin
                        buf_q      <= md_result_i;
                        wait_cnt_q <= '0;
                        state_q    <= PEND;
                    end
                    if (md_start_i) err_q <= 1'b1;
                end
                PEND: begin
                    if (force_dbl)     state_q    <= IDLE;
                    else if (wb_wen_i) wait_cnt_q <= wait_cnt_q + 1'b1;
                    if (md_start_i)    err_q      <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (busy_o && wb_wen_i && wb_hilo) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hilo_wr_sched.sv
// Scoreboard bench for hilo_wr_sched. Stimulus pushes the expected outputs for each cycle,
// and a negedge monitor pops those entries and compares them with the selected instance (MAX_WAIT=4 or 0).
module tb_hilo_wr_sched;
    logic        clk = 1'b0;
    logic        rstn;
    logic        md_start, md_done, id_valid, id_hilo_wr, wb_wen;
    logic [63:0] md_result;
    logic [5:0]  id_raddr1, id_raddr2, wb_waddr;
    logic [31:0] wb_wdata;

    logic        id_stall[2], wb_stall[2], rf_wen[2], rf_dbl[2], busy[2], err[2];
    logic [5:0]  rf_waddr[2];
    logic [31:0] rf_wdata[2];
    logic [63:0] rf_dwdata[2];

    always #5 clk = ~clk;

    hilo_wr_sched #(.MAX_WAIT(4)) u4 (
        .clk(clk), .rstn(rstn), .md_start_i(md_start), .md_done_i(md_done),
        .md_result_i(md_result), .id_valid_i(id_valid), .id_raddr1_i(id_raddr1),
        .id_raddr2_i(id_raddr2), .id_hilo_wr_i(id_hilo_wr), .id_stall_o(id_stall[0]),
        .wb_wen_i(wb_wen), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .wb_stall_o(wb_stall[0]), .rf_wen_o(rf_wen[0]), .rf_waddr_o(rf_waddr[0]),
        .rf_wdata_o(rf_wdata[0]), .rf_double_en_o(rf_dbl[0]),
        .rf_double_wdata_o(rf_dwdata[0]), .busy_o(busy[0]), .err_o(err[0]));

    hilo_wr_sched #(.MAX_WAIT(0)) u0 (
        .clk(clk), .rstn(rstn), .md_start_i(md_start), .md_done_i(md_done),
        .md_result_i(md_result), .id_valid_i(id_valid), .id_raddr1_i(id_raddr1),
        .id_raddr2_i(id_raddr2), .id_hilo_wr_i(id_hilo_wr), .id_stall_o(id_stall[1]),
        .wb_wen_i(wb_wen), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .wb_stall_o(wb_stall[1]), .rf_wen_o(rf_wen[1]), .rf_waddr_o(rf_waddr[1]),
        .rf_wdata_o(rf_wdata[1]), .rf_double_en_o(rf_dbl[1]),
        .rf_double_wdata_o(rf_dwdata[1]), .busy_o(busy[1]), .err_o(err[1]));

    typedef struct {
        string       name;
        int          sel;
        logic        wen, dbl, wbst, idst, bsy, er;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [63:0] ddata;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0, n_fail = 0;
    string       tname;
    logic [63:0] exp_buf;
    int          cyc_no;

    // One entry per cycle. Address/data fields matter only when the matching write is expected.
    task automatic chk(input int sel, input logic wen, dbl, wbst, idst, bsy, er);
        exp_t e;
        e.name = $sformatf("%s.c%0d", tname, cyc_no);
        e.sel = sel; e.wen = wen; e.dbl = dbl; e.wbst = wbst; e.idst = idst;
        e.bsy = bsy; e.er = er; e.waddr = wb_waddr; e.wdata = wb_wdata; e.ddata = exp_buf;
        q.push_back(e);
        @(posedge clk); #1;
        md_start = 1'b0; md_done = 1'b0;
        cyc_no++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            int   s;
            bit   bad;
            e = q.pop_front();
            s = e.sel;
            bad = (rf_wen[s] !== e.wen) || (rf_dbl[s] !== e.dbl) || (wb_stall[s] !== e.wbst) ||
                  (id_stall[s] !== e.idst) || (busy[s] !== e.bsy) || (err[s] !== e.er) ||
                  (e.wen && (rf_waddr[s] !== e.waddr || rf_wdata[s] !== e.wdata)) ||
                  (e.dbl && rf_dwdata[s] !== e.ddata);
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s: got wen=%b dbl=%b wbst=%b idst=%b busy=%b err=%b wa=%0d wd=%h dd=%h; want wen=%b dbl=%b wbst=%b idst=%b busy=%b err=%b wa=%0d wd=%h dd=%h",
                         e.name, rf_wen[s], rf_dbl[s], wb_stall[s], id_stall[s], busy[s], err[s],
                         rf_waddr[s], rf_wdata[s], rf_dwdata[s], e.wen, e.dbl, e.wbst, e.idst,
                         e.bsy, e.er, e.waddr, e.wdata, e.ddata);
            end
        end
    end

    task automatic do_reset(input string nm);
        tname = nm; cyc_no = 0;
        rstn = 1'b0; md_start = 0; md_done = 0; md_result = '0; id_valid = 0;
        id_raddr1 = '0; id_raddr2 = '0; id_hilo_wr = 0; wb_wen = 0; wb_waddr = '0; wb_wdata = '0;
        @(posedge clk); #1;
        chk(0, 0, 0, 0, 0, 0, 0);
        chk(1, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
    endtask

    initial begin
        // Test 1: clean result, no WB conflict
        do_reset("rst1");
        tname = "t1"; cyc_no = 0; exp_buf = 64'h5_0000_0007;
        md_start = 1; chk(0, 0, 0, 0, 0, 0, 0);
        chk(0, 0, 0, 0, 0, 1, 0);
        chk(0, 0, 0, 0, 0, 1, 0);
        md_done = 1; md_result = 64'h5_0000_0007; chk(0, 0, 0, 0, 0, 1, 0);
        md_result = '0; chk(0, 0, 1, 0, 0, 1, 0);
        chk(0, 0, 0, 0, 0, 0, 0);

        // Test 2: WB holds the port until the wait budget runs out
        do_reset("rst2");
        tname = "t2"; cyc_no = 0; exp_buf = 64'hAAAA_BBBB_CCCC_DDDD;
        md_start = 1; chk(0, 0, 0, 0, 0, 0, 0);
        chk(0, 0, 0, 0, 0, 1, 0);
        chk(0, 0, 0, 0, 0, 1, 0);
        md_done = 1; md_result = exp_buf; chk(0, 0, 0, 0, 0, 1, 0);
        wb_wen = 1; wb_waddr = 6'd5;
        for (int k = 0; k < 4; k++) begin
            wb_wdata = 32'h1234_0000 + k; chk(0, 1, 0, 0, 0, 1, 0);
        end
        wb_wdata = 32'hFEED_0008; chk(0, 0, 1, 1, 0, 1, 0);
        chk(0, 1, 0, 0, 0, 0, 0);
        wb_wen = 0;

        // Test 3: ID hazard on HI/LO
        do_reset("rst3");
        tname = "t3"; cyc_no = 0; exp_buf = 64'h1;
        id_valid = 1; id_raddr1 = 6'd32;
        md_start = 1; chk(0, 0, 0, 0, 0, 0, 0);
        chk(0, 0, 0, 0, 1, 1, 0);
        md_done = 1; md_result = 64'h1; chk(0, 0, 0, 0, 1, 1, 0);
        chk(0, 0, 1, 0, 1, 1, 0);
        chk(0, 0, 0, 0, 0, 0, 0);
        id_raddr1 = 6'd5; exp_buf = 64'h2;
        md_start = 1; chk(0, 0, 0, 0, 0, 0, 0);
        chk(0, 0, 0, 0, 0, 1, 0);
        id_hilo_wr = 1; md_done = 1; md_result = 64'h2; chk(0, 0, 0, 0, 1, 1, 0);
        chk(0, 0, 1, 0, 1, 1, 0);
        chk(0, 0, 0, 0, 0, 0, 0);
        id_hilo_wr = 0; id_valid = 0;

        // Test 4: reset while a result is pending
        do_reset("rst4");
        tname = "t4"; cyc_no = 0; exp_buf = 64'h0;
        md_start = 1; chk(0, 0, 0, 0, 0, 0, 0);
        chk(0, 0, 0, 0, 0, 1, 0);
        md_done = 1; md_result = 64'hDEAD_BEEF_0000_1111; chk(0, 0, 0, 0, 0, 1, 0);
        rstn = 0; chk(0, 0, 0, 0, 0, 1, 0);
        rstn = 1; chk(0, 0, 0, 0, 0, 0, 0);
        chk(0, 0, 0, 0, 0, 0, 0);
        exp_buf = 64'h3_0000_0004;
        md_start = 1; chk(0, 0, 0, 0, 0, 0, 0);
        chk(0, 0, 0, 0, 0, 1, 0);
        md_done = 1; md_result = exp_buf; chk(0, 0, 0, 0, 0, 1, 0);
        chk(0, 0, 1, 0, 0, 1, 0);
        chk(0, 0, 0, 0, 0, 0, 0);

        // Test 5: protocol errors are sticky until reset
        do_reset("rst5");
        tname = "t5"; cyc_no = 0;
        md_done = 1; md_result = 64'h77; chk(0, 0, 0, 0, 0, 0, 0);
        md_start = 1; chk(0, 0, 0, 0, 0, 0, 1);
        wb_wen = 1; wb_waddr = 6'd33; wb_wdata = 32'hC0DE; chk(0, 1, 0, 0, 0, 1, 1);
        wb_wen = 0; chk(0, 0, 0, 0, 0, 1, 1);
        do_reset("rst5b");
        tname = "t5b"; cyc_no = 0; exp_buf = 64'h9;
        md_start = 1; md_done = 1; md_result = 64'h55; chk(0, 0, 0, 0, 0, 0, 0);
        chk(0, 0, 0, 0, 0, 1, 1);
        md_done = 1; md_result = 64'h9; chk(0, 0, 0, 0, 0, 1, 1);
        chk(0, 0, 1, 0, 0, 1, 1);
        chk(0, 0, 0, 0, 0, 0, 1);

        // Test 6: MAX_WAIT=0 forces the double write ahead of WB immediately
        do_reset("rst6");
        tname = "t6"; cyc_no = 0; exp_buf = 64'h1111_2222_3333_4444;
        md_start = 1; chk(1, 0, 0, 0, 0, 0, 0);
        chk(1, 0, 0, 0, 0, 1, 0);
        chk(1, 0, 0, 0, 0, 1, 0);
        md_done = 1; md_result = exp_buf; chk(1, 0, 0, 0, 0, 1, 0);
        wb_wen = 1; wb_waddr = 6'd7; wb_wdata = 32'hABCD; chk(1, 0, 1, 1, 0, 1, 0);
        chk(1, 1, 0, 0, 0, 0, 0);
        wb_wen = 0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end
endmodule
